// File: rtl/ram_master_pkg.sv
// Shared bus widths, access-size encodings and request helpers for the
// ram_master slice.
package ram_master_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  // Load-side fields that must survive from accept until the response.
  typedef struct packed {
    logic [1:0] size;
    logic       sgn;
    logic [1:0] offset;
  } req_info_t;

  // The reserved encoding 11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    logic [1:0] res;
    if (size == 2'b11) begin
      res = MEM_SIZE_WORD;
    end else begin
      res = size;
    end
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic res;
    case (norm_size(size))
      MEM_SIZE_HALF: res = offset[0];
      MEM_SIZE_WORD: res = (offset != 2'b00);
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ram_master_if.sv
// CPU request/response handshake plus the word-organised SRAM port.
interface ram_master_if;
  import ram_master_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [ADDR_BUS-1:0] req_addr;
  logic [DATA_BUS-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_err;
  logic [DATA_BUS-1:0] resp_rdata;
  logic                ram_en;
  logic [3:0]          ram_write_sel;
  logic [ADDR_BUS-1:0] ram_addr;
  logic [DATA_BUS-1:0] ram_wdata;
  logic [DATA_BUS-1:0] ram_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output ram_en, ram_write_sel, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  ram_en, ram_write_sel, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// Little-endian byte-lane formatting: store mask/replication and load
// extraction with sign or zero extension. Purely combinational.
module mem_lane_fmt
  import ram_master_pkg::*;
(
  input  logic [1:0]          st_size,
  input  logic [1:0]          st_offset,
  input  logic [DATA_BUS-1:0] st_wdata,
  output logic [3:0]          st_mask,
  output logic [DATA_BUS-1:0] st_wdata_rep,
  input  logic [1:0]          ld_size,
  input  logic [1:0]          ld_offset,
  input  logic                ld_signed,
  input  logic [DATA_BUS-1:0] ld_rdata,
  output logic [DATA_BUS-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: lane strobes and data replicated across every lane.
  always_comb begin
    st_mask      = 4'b1111;
    st_wdata_rep = st_wdata;
    case (norm_size(st_size))
      MEM_SIZE_BYTE: begin
        st_mask      = 4'b0001 << st_offset;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_mask      = st_offset[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: begin
        st_mask      = 4'b1111;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  // Load side: pick the addressed lane(s) and extend to the full word.
  always_comb begin
    case (ld_offset)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    if (ld_offset[1]) begin
      ld_half = ld_rdata[31:16];
    end else begin
      ld_half = ld_rdata[15:0];
    end
    case (norm_size(ld_size))
      MEM_SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      MEM_SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default:       ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/ram_master.sv
// Single-request bus initiator from the MEM stage onto the SRAM port; stores
// keep address, lanes and data stable for one extra cycle while the RAM commits.
module ram_master
  import ram_master_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  ram_master_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  req_info_t           info_q, info_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_BUS-1:0] resp_rdata_q, resp_rdata_d;
  logic                ram_en_q, ram_en_d;
  logic [3:0]          ram_write_sel_q, ram_write_sel_d;
  logic [ADDR_BUS-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_BUS-1:0] ram_wdata_q, ram_wdata_d;

  logic [3:0]          st_mask_s;
  logic [DATA_BUS-1:0] st_wdata_rep_s;
  logic [DATA_BUS-1:0] ld_data_s;
  logic                accept_s;

  mem_lane_fmt u_lane_fmt (
    .st_size      (bus.req_size),
    .st_offset    (bus.req_addr[1:0]),
    .st_wdata     (bus.req_wdata),
    .st_mask      (st_mask_s),
    .st_wdata_rep (st_wdata_rep_s),
    .ld_size      (info_q.size),
    .ld_offset    (info_q.offset),
    .ld_signed    (info_q.sgn),
    .ld_rdata     (bus.ram_rdata),
    .ld_data      (ld_data_s)
  );

  assign accept_s = bus.req_valid & req_ready_q;

  // Next-state and next-output logic; bus outputs are computed one cycle
  // ahead so every ram_* and resp_* pin comes straight from a flop.
  always_comb begin
    state_d         = state_q;
    info_d          = info_q;
    resp_valid_d    = 1'b0;
    resp_err_d      = 1'b0;
    resp_rdata_d    = {DATA_BUS{1'b0}};
    ram_en_d        = 1'b0;
    ram_write_sel_d = ram_write_sel_q;
    ram_addr_d      = ram_addr_q;
    ram_wdata_d     = ram_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          info_d = '{size: bus.req_size, sgn: bus.req_signed, offset: bus.req_addr[1:0]};
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_write) begin
            state_d         = ST_WRITE;
            ram_en_d        = 1'b1;
            ram_write_sel_d = st_mask_s;
            ram_addr_d      = {bus.req_addr[ADDR_BUS-1:2], 2'b00};
            ram_wdata_d     = st_wdata_rep_s;
          end else begin
            state_d         = ST_READ;
            ram_en_d        = 1'b1;
            ram_write_sel_d = 4'b0000;
            ram_addr_d      = {bus.req_addr[ADDR_BUS-1:2], 2'b00};
            ram_wdata_d     = {DATA_BUS{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d         = ST_RESP;
        resp_valid_d    = 1'b1;
        resp_rdata_d    = ld_data_s;
        ram_write_sel_d = 4'b0000;
        ram_addr_d      = {ADDR_BUS{1'b0}};
        ram_wdata_d     = {DATA_BUS{1'b0}};
      end
      ST_WRITE: begin
        // Enable drops but address, lanes and data stay put for the commit.
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d         = ST_RESP;
        resp_valid_d    = 1'b1;
        ram_write_sel_d = 4'b0000;
        ram_addr_d      = {ADDR_BUS{1'b0}};
        ram_wdata_d     = {DATA_BUS{1'b0}};
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d         = ST_IDLE;
        ram_write_sel_d = 4'b0000;
        ram_addr_d      = {ADDR_BUS{1'b0}};
        ram_wdata_d     = {DATA_BUS{1'b0}};
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      info_q          <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= {DATA_BUS{1'b0}};
      ram_en_q        <= 1'b0;
      ram_write_sel_q <= 4'b0000;
      ram_addr_q      <= {ADDR_BUS{1'b0}};
      ram_wdata_q     <= {DATA_BUS{1'b0}};
    end else begin
      state_q         <= state_d;
      info_q          <= info_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
      ram_en_q        <= ram_en_d;
      ram_write_sel_q <= ram_write_sel_d;
      ram_addr_q      <= ram_addr_d;
      ram_wdata_q     <= ram_wdata_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.ram_en        = ram_en_q;
  assign bus.ram_write_sel = ram_write_sel_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a byte-lane SRAM model whose commit
// happens one cycle after the write request and is gated by rst.
`timescale 1ns/1ps
module tb_ram_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_clear = 1'b1;
  logic we_dly = 1'b0;
  logic [31:0] mem [64];
  int passed = 0;
  int total  = 0;

  ram_master_if bus();

  ram_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.ram_rdata = (bus.ram_addr < 32'h100) ? mem[bus.ram_addr[7:2]] : 32'h0;

  // RAM model: the write strobe is delayed one cycle and commits with the
  // address/lanes/data present at that later edge.
  always @(posedge clk) begin
    we_dly <= rst && bus.ram_en && (bus.ram_write_sel != 4'b0000);
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (we_dly && rst && (bus.ram_addr < 32'h100)) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_write_sel[b]) mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  // Present a request and return at the falling edge of the cycle after accept.
  task automatic start(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
      bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = d;
      if (bus.req_ready) acc = 1'b1;
    end
    total++;
    if (!acc) $display("FAIL accept_timeout addr=%h: ready never seen, required 1", a);
    else passed++;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         output logic v, output logic [31:0] d);
    start(1'b0, sz, sg, a, 32'h0);
    @(negedge clk);
    v = bus.resp_valid;
    d = bus.resp_rdata;
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          output logic v);
    start(1'b1, sz, 1'b0, a, d);
    repeat (2) @(negedge clk);
    v = bus.resp_valid;
  endtask

  task automatic test_reset();
    logic [103:0] got;
    rst = 1'b0; mem_clear = 1'b1;
    repeat (3) @(negedge clk);
    got = {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
           bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata};
    total++;
    if (got !== 104'h0) $display("FAIL reset_outputs: got %h, required 0", got);
    else passed++;
    mem_clear = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.req_ready);
    else passed++;
  endtask

  task automatic test_word_store_load();
    logic v; logic [31:0] d;
    start(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    total++;
    if ({bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata} !== {1'b1, 4'b1111, 32'h10, 32'h12345678})
      $display("FAIL wstore_write: en=%b sel=%b addr=%h wd=%h, required 1 1111 10 12345678",
               bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata, bus.resp_valid} !== {1'b0, 4'b1111, 32'h10, 32'h12345678, 1'b0})
      $display("FAIL wstore_hold: en=%b sel=%b addr=%h wd=%h rv=%b, required 0 1111 10 12345678 0",
               bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata, bus.resp_valid);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL wstore_resp: rv=%b err=%b rd=%h, required 1 0 0", bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else passed++;
    start(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    total++;
    if ({bus.ram_en, bus.ram_write_sel, bus.ram_addr} !== {1'b1, 4'b0000, 32'h10})
      $display("FAIL wload_read: en=%b sel=%b addr=%h, required 1 0000 10", bus.ram_en, bus.ram_write_sel, bus.ram_addr);
    else passed++;
    @(negedge clk);
    v = bus.resp_valid; d = bus.resp_rdata;
    total++;
    if ({v, d} !== {1'b1, 32'h12345678}) $display("FAIL wload_resp: rv=%b rd=%h, required 1 12345678", v, d);
    else passed++;
    @(negedge clk);
    total++;
    if ({bus.resp_valid, bus.resp_rdata} !== 33'h0) $display("FAIL resp_clear: rv=%b rd=%h, required 0 0", bus.resp_valid, bus.resp_rdata);
    else passed++;
  endtask

  task automatic test_byte_stores();
    logic v; logic [31:0] d;
    logic [31:0] addrs [2] = '{32'h21, 32'h23};
    logic [3:0]  masks [2] = '{4'b0010, 4'b1000};
    for (int i = 0; i < 2; i++) begin
      start(1'b1, 2'b00, 1'b0, addrs[i], 32'hABCD125A);
      total++;
      if ({bus.ram_write_sel, bus.ram_addr, bus.ram_wdata} !== {masks[i], 32'h20, 32'h5A5A5A5A})
        $display("FAIL bstore_lanes%0d: sel=%b addr=%h wd=%h, required %b 20 5a5a5a5a",
                 i, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata, masks[i]);
      else passed++;
      repeat (2) @(negedge clk);
    end
    do_load(2'b10, 1'b0, 32'h20, v, d);
    total++;
    if ({v, d} !== {1'b1, 32'h5A005A00}) $display("FAIL bstore_readback: rv=%b rd=%h, required 1 5a005a00", v, d);
    else passed++;
  endtask

  task automatic test_extend();
    logic v; logic [31:0] d;
    logic [31:0] a   [9] = '{32'h50, 32'h50, 32'h52, 32'h52, 32'h51, 32'h53, 32'h53, 32'h50, 32'h50};
    logic [1:0]  sz  [9] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
    logic        sg  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hFFFFFFFF,
                             32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h8001FF80};
    do_store(2'b10, 32'h50, 32'h8001FF80, v);
    total++;
    if (v !== 1'b1) $display("FAIL ext_store_resp: rv=%b, required 1", v);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      do_load(sz[i], sg[i], a[i], v, d);
      total++;
      if ({v, d} !== {1'b1, exp[i]})
        $display("FAIL ext_load%0d addr=%h sz=%b s=%b: rv=%b rd=%h, required 1 %h", i, a[i], sz[i], sg[i], v, d, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_misaligned();
    logic v; logic [31:0] d;
    logic        w  [2] = '{1'b0, 1'b1};
    logic [1:0]  sz [2] = '{2'b01, 2'b10};
    logic [31:0] a  [2] = '{32'h31, 32'h32};
    for (int i = 0; i < 2; i++) begin
      start(w[i], sz[i], 1'b0, a[i], 32'hFFFFFFFF);
      total++;
      if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_en} !== {1'b1, 1'b1, 32'h0, 1'b0})
        $display("FAIL misalign%0d_resp: rv=%b err=%b rd=%h en=%b, required 1 1 0 0",
                 i, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.ram_en);
      else passed++;
      @(negedge clk);
      total++;
      if ({bus.resp_valid, bus.resp_err, bus.ram_en} !== 3'b000)
        $display("FAIL misalign%0d_after: rv=%b err=%b en=%b, required 000", i, bus.resp_valid, bus.resp_err, bus.ram_en);
      else passed++;
    end
    do_load(2'b10, 1'b0, 32'h30, v, d);
    total++;
    if ({v, d} !== {1'b1, 32'h0}) $display("FAIL misalign_nowrite: rv=%b rd=%h, required 1 0", v, d);
    else passed++;
  endtask

  task automatic test_reset_mid_store();
    logic v; logic [31:0] d;
    logic [103:0] got;
    do_store(2'b10, 32'h40, 32'hCAFEF00D, v);
    start(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
           bus.ram_en, bus.ram_write_sel, bus.ram_addr, bus.ram_wdata};
    total++;
    if (got !== 104'h0) $display("FAIL midrst_outputs: got %h, required 0", got);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) $display("FAIL midrst_ready: rdy=%b rv=%b, required 1 0", bus.req_ready, bus.resp_valid);
    else passed++;
    do_load(2'b10, 1'b0, 32'h40, v, d);
    total++;
    if ({v, d} !== {1'b1, 32'hCAFEF00D}) $display("FAIL midrst_old_value: rv=%b rd=%h, required 1 cafef00d", v, d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic v;
    logic [31:0] vals [4] = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    logic [31:0] got [4];
    int acc_cyc [4];
    int n_acc = 0;
    int n_resp = 0;
    for (int i = 0; i < 4; i++) do_store(2'b10, 32'h60 + 32'(4*i), vals[i], v);
    for (int cyc = 0; cyc < 60 && n_resp < 4; cyc++) begin
      @(negedge clk);
      if (bus.resp_valid && n_resp < 4) begin
        got[n_resp] = bus.resp_rdata;
        n_resp++;
      end
      bus.req_valid = (n_acc < 4); bus.req_write = 1'b0; bus.req_size = 2'b10;
      bus.req_signed = 1'b0; bus.req_addr = 32'h60 + 32'(4*n_acc);
      if (bus.req_ready && n_acc < 4) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
    bus.req_valid = 1'b0;
    total++;
    if (n_resp !== 4) $display("FAIL b2b_count: got %0d responses, required 4", n_resp);
    else passed++;
    for (int i = 1; i < n_acc; i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 3)
        $display("FAIL b2b_interval%0d: got %0d cycles, required 3", i, acc_cyc[i] - acc_cyc[i-1]);
      else passed++;
    end
    for (int i = 0; i < n_resp; i++) begin
      total++;
      if (got[i] !== vals[i]) $display("FAIL b2b_data%0d: got %h, required %h", i, got[i], vals[i]);
      else passed++;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_stores();
    test_extend();
    test_misaligned();
    test_reset_mid_store();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
